// File: rtl/e_mdu_param.sv
// Parametrised E-stage multiply/divide unit with HI/LO registers, multiply-accumulate/subtract,
// flush/abort, and a one-cycle Done pulse on every commit.
module e_mdu_param #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       MDType,
    input  logic             Flush,
    output logic [WIDTH-1:0] HIOut,
    output logic [WIDTH-1:0] LOOut,
    output logic             Start,
    output logic             Busy,
    output logic             Done
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] W_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_hi;
    logic [WIDTH-1:0]       r_lo;
    logic [WIDTH-1:0]       r_sh;
    logic [WIDTH-1:0]       r_sl;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_is_mul;
    logic                   w_is_div;
    logic                   w_signed;
    logic                   w_start;
    logic [2*WIDTH-1:0]     w_ext_a;
    logic [2*WIDTH-1:0]     w_ext_b;
    logic [2*WIDTH-1:0]     w_prod;
    logic [2*WIDTH-1:0]     w_hilo;
    logic [2*WIDTH-1:0]     w_res;
    logic                   w_neg_a;
    logic                   w_neg_b;
    logic [WIDTH-1:0]       w_mag_a;
    logic [WIDTH-1:0]       w_mag_b;
    logic [WIDTH-1:0]       w_dvsr;
    logic [WIDTH-1:0]       w_q_mag;
    logic [WIDTH-1:0]       w_r_mag;
    logic [WIDTH-1:0]       w_quot;
    logic [WIDTH-1:0]       w_rem;

    // Op decode: classify MDType into multiply-class, divide-class and signedness.
    always_comb begin
        w_is_mul = 1'b0;
        w_is_div = 1'b0;
        w_signed = 1'b0;
        case (MDType)
            OP_MULT:  begin w_is_mul = 1'b1; w_signed = 1'b1; end
            OP_MULTU: begin w_is_mul = 1'b1; end
            OP_DIV:   begin w_is_div = 1'b1; w_signed = 1'b1; end
            OP_DIVU:  begin w_is_div = 1'b1; end
            OP_MADD:  begin w_is_mul = 1'b1; w_signed = 1'b1; end
            OP_MADDU: begin w_is_mul = 1'b1; end
            OP_MSUB:  begin w_is_mul = 1'b1; w_signed = 1'b1; end
            OP_MSUBU: begin w_is_mul = 1'b1; end
            default:  begin w_is_mul = 1'b0; end
        endcase
    end

    assign w_start = (w_is_mul | w_is_div) & ~r_busy & ~Flush;

    assign w_ext_a = w_signed ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
    assign w_ext_b = w_signed ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
    assign w_prod  = w_ext_a * w_ext_b;
    assign w_hilo  = {r_hi, r_lo};

    // Signed division runs on magnitudes; magnitude of MIN wraps to 2^(W-1), which gives MIN/-1 -> MIN, 0.
    assign w_neg_a = w_signed & A[WIDTH-1];
    assign w_neg_b = w_signed & B[WIDTH-1];
    assign w_mag_a = w_neg_a ? (~A + W_ONE) : A;
    assign w_mag_b = w_neg_b ? (~B + W_ONE) : B;
    assign w_dvsr  = (B == '0) ? W_ONE : w_mag_b;
    assign w_q_mag = w_mag_a / w_dvsr;
    assign w_r_mag = w_mag_a % w_dvsr;
    assign w_quot  = (w_neg_a ^ w_neg_b) ? (~w_q_mag + W_ONE) : w_q_mag;
    assign w_rem   = w_neg_a ? (~w_r_mag + W_ONE) : w_r_mag;

    // Result selection for the shadow registers; divide by zero preserves HI/LO.
    always_comb begin
        w_res = w_hilo;
        case (MDType)
            OP_MULT, OP_MULTU:            w_res = w_prod;
            OP_MADD, OP_MADDU:            w_res = w_hilo + w_prod;
            OP_MSUB, OP_MSUBU:            w_res = w_hilo - w_prod;
            OP_DIV, OP_DIVU: begin
                if (B == '0) begin
                    w_res = w_hilo;
                end else begin
                    w_res = {w_rem, w_quot};
                end
            end
            default:                      w_res = w_hilo;
        endcase
    end

    // Control FSM, latency counter and HI/LO/shadow state.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
            r_hi    <= '0;
            r_lo    <= '0;
            r_sh    <= '0;
            r_sl    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_sh    <= w_res[2*WIDTH-1:WIDTH];
                        r_sl    <= w_res[WIDTH-1:0];
                        r_cnt   <= w_is_div ? DIV_CNT : MUL_CNT;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else if (!Flush && MDType == OP_MTHI) begin
                        r_hi <= A;
                    end else if (!Flush && MDType == OP_MTLO) begin
                        r_lo <= A;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (Flush) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == CNT_ONE) begin
                        r_hi    <= r_sh;
                        r_lo    <= r_sl;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign HIOut = r_hi;
    assign LOOut = r_lo;
    assign Start = w_start;
    assign Busy  = r_busy;
    assign Done  = r_done;

endmodule

// File: tb/tb_e_mdu_param.sv
// Directed bench for e_mdu_param: a 32-bit instance driven by a vector table plus corner
// sequences, and a 16-bit/MUL_LAT=1 instance for the parameter sweep.
module tb_e_mdu_param;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] A, B;
    logic [3:0]  MDType;
    logic        Flush;
    logic [31:0] HIOut, LOOut;
    logic        Start, Busy, Done;

    logic [15:0] A16, B16;
    logic [3:0]  MDType16;
    logic        Flush16;
    logic [15:0] HIOut16, LOOut16;
    logic        Start16, Busy16, Done16;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    e_mdu_param #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10), .CNT_W(5)) u_dut (
        .Clk(Clk), .Reset(Reset), .A(A), .B(B), .MDType(MDType), .Flush(Flush),
        .HIOut(HIOut), .LOOut(LOOut), .Start(Start), .Busy(Busy), .Done(Done)
    );

    e_mdu_param #(.WIDTH(16), .MUL_LAT(1), .DIV_LAT(3), .CNT_W(3)) u_dut16 (
        .Clk(Clk), .Reset(Reset), .A(A16), .B(B16), .MDType(MDType16), .Flush(Flush16),
        .HIOut(HIOut16), .LOOut(LOOut16), .Start(Start16), .Busy(Busy16), .Done(Done16)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic fl);
        MDType = op;
        A      = a;
        B      = b;
        Flush  = fl;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            cyc();
            drive(4'd0, 32'd0, 32'd0, 1'b0);
        end
    endtask

    initial begin
        tbl[0]  = '{4'd1,  32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
        tbl[1]  = '{4'd7,  32'd1,        32'd0,        0,  32'h00000001, 32'hFFFFFFFA};
        tbl[2]  = '{4'd8,  32'hFFFFFFFF, 32'd0,        0,  32'h00000001, 32'hFFFFFFFF};
        tbl[3]  = '{4'd10, 32'd2,        32'd1,        5,  32'h00000002, 32'h00000001};
        tbl[4]  = '{4'd11, 32'd1,        32'd1,        5,  32'h00000002, 32'h00000000};
        tbl[5]  = '{4'd3,  32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[6]  = '{4'd4,  32'd7,        32'd0,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[7]  = '{4'd3,  32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        tbl[8]  = '{4'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
        tbl[9]  = '{4'd9,  32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000002};
        tbl[10] = '{4'd12, 32'd2,        32'd3,        5,  32'hFFFFFFFD, 32'hFFFFFFFC};
        tbl[11] = '{4'd4,  32'd100,      32'd7,        10, 32'h00000002, 32'h0000000E};
        tbl[12] = '{4'd3,  32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
        tbl[13] = '{4'd13, 32'd55,       32'd5,        0,  32'h00000001, 32'hFFFFFFFD};
        tbl[14] = '{4'd6,  32'd9,        32'd9,        0,  32'h00000001, 32'hFFFFFFFD};

        Reset = 1'b0;
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        MDType16 = 4'd0; A16 = 16'd0; B16 = 16'd0; Flush16 = 1'b0;
        #12;
        chk("rst_hi", HIOut, 0); chk("rst_lo", LOOut, 0);
        chk("rst_busy", Busy, 0); chk("rst_done", Done, 0);
        #1 Reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            cyc();
            drive(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0);
            #1;
            chk($sformatf("v%0d_start", i), Start, (tbl[i].lat > 0) ? 1 : 0);
            chk($sformatf("v%0d_done0", i), Done, 0);
            if (tbl[i].lat > 0) begin
                for (int k = 1; k <= tbl[i].lat; k++) begin
                    cyc();
                    drive(4'd0, 32'd0, 32'd0, 1'b0);
                    #1;
                    chk($sformatf("v%0d_busy_c%0d", i, k), {Busy, Done}, 2'b10);
                end
            end
            cyc();
            drive(4'd0, 32'd0, 32'd0, 1'b0);
            #1;
            chk($sformatf("v%0d_hi", i), HIOut, tbl[i].hi);
            chk($sformatf("v%0d_lo", i), LOOut, tbl[i].lo);
            chk($sformatf("v%0d_done", i), {Busy, Done}, (tbl[i].lat > 0) ? 2'b01 : 2'b00);
        end

        // Flush in cycle 3 of a mult: abort without commit.
        cyc(); drive(4'd1, 32'd5, 32'd5, 1'b0); #1 chk("fl_start", Start, 1);
        idle(2);
        cyc(); drive(4'd0, 32'd0, 32'd0, 1'b1); #1 chk("fl_busy_c3", Busy, 1);
        cyc(); drive(4'd0, 32'd0, 32'd0, 1'b0); #1 chk("fl_busy_c4", {Busy, Done}, 2'b00);
        for (int k = 0; k < 4; k++) begin
            cyc(); #1;
            chk("fl_nodone", Done, 0);
        end
        chk("fl_hilo", {HIOut, LOOut}, 64'h00000001_FFFFFFFD);

        // Flush together with issue, and with mtlo, in IDLE.
        cyc(); drive(4'd3, 32'd9, 32'd3, 1'b1); #1 chk("fli_start", Start, 0);
        cyc(); drive(4'd8, 32'd5, 32'd0, 1'b1); #1 chk("fli_busy", Busy, 0);
        cyc(); drive(4'd0, 32'd0, 32'd0, 1'b0); #1 chk("fli_lo", LOOut, 32'hFFFFFFFD);

        // Compute op and mtlo presented while busy are ignored.
        cyc(); drive(4'd2, 32'd3, 32'd4, 1'b0); #1 chk("bz_start", Start, 1);
        cyc(); drive(4'd3, 32'd9, 32'd3, 1'b0); #1 chk("bz_start_blk", Start, 0);
        cyc(); drive(4'd8, 32'd5, 32'd0, 1'b0);
        idle(3);
        cyc(); #1 chk("bz_commit", {Done, HIOut, LOOut}, {1'b1, 64'h00000000_0000000C});
        cyc(); #1 chk("bz_after", {Busy, Done, LOOut}, {2'b00, 32'h0000000C});

        // Flush in the same cycle as counter==1: no commit.
        cyc(); drive(4'd1, 32'd2, 32'd2, 1'b0);
        idle(4);
        cyc(); drive(4'd0, 32'd0, 32'd0, 1'b1); #1 chk("flc_busy", Busy, 1);
        cyc(); drive(4'd0, 32'd0, 32'd0, 1'b0); #1
        chk("flc_nocommit", {Busy, Done, HIOut, LOOut}, {2'b00, 64'h00000000_0000000C});

        // A new op may issue in the Done cycle.
        cyc(); drive(4'd1, 32'd1, 32'd1, 1'b0);
        idle(5);
        cyc(); drive(4'd2, 32'd2, 32'd2, 1'b0); #1
        chk("dc_done_start", {Done, Start, LOOut}, {2'b11, 32'd1});
        idle(5);
        cyc(); #1 chk("dc_commit2", {Done, HIOut, LOOut}, {1'b1, 64'h00000000_00000004});

        // Parameter sweep: W=16, MUL_LAT=1.
        cyc(); MDType16 = 4'd1; A16 = 16'h8000; B16 = 16'h8000; #1 chk("w16_start", Start16, 1);
        cyc(); MDType16 = 4'd0; #1 chk("w16_busy", {Busy16, Done16}, 2'b10);
        cyc(); #1 chk("w16_commit", {Busy16, Done16, HIOut16, LOOut16}, {2'b01, 16'h4000, 16'h0000});
        cyc(); #1 chk("w16_done_end", Done16, 0);

        // Asynchronous reset mid-run with counter==3.
        cyc(); drive(4'd1, 32'd7, 32'd7, 1'b0);
        idle(3);
        Reset = 1'b0;
        #1 chk("arst_now", {Busy, Done, HIOut, LOOut}, 66'd0);
        #2 Reset = 1'b1;
        idle(8);
        #1 chk("arst_idle", {Busy, Done, HIOut, LOOut}, 66'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
